// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM/owner codes and the read-tag format.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } arb_state_t;

  // One in-flight read: valid marks a real read, own is the issuing master (0=m0, 1=m1).
  typedef struct packed {
    logic valid;
    logic own;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register that carries read tags alongside the memory read latency.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single memory port: round-robin with bounded hold,
// and read-data steering back to the issuing master.
//
// state | meaning
// IDLE  | nobody owns the port, memory outputs driven to zero
// OWN0  | master 0 owns the port
// OWN1  | master 1 owns the port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  arb_state_t state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       last, last_nxt;
  logic       issue0, issue1;
  rd_tag_t    tag_in, tag_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

  // hold_cnt only counts while the other master waits; reaching HOLD_MAX forces rotation,
  // so the increment below can never pass HOLD_MAX.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)                            state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && hold_cnt == HOLD_MAX) state_nxt = OWN1;
        else if (m1_req)                         hold_nxt  = hold_cnt + 8'd1;
        if (state_nxt != OWN0) last_nxt = 1'b0;
      end
      OWN1: begin
        if (!m1_req)                            state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && hold_cnt == HOLD_MAX) state_nxt = OWN0;
        else if (m0_req)                         hold_nxt  = hold_cnt + 8'd1;
        if (state_nxt != OWN1) last_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);
  assign owner  = state;
  assign issue0 = m0_gnt & m0_req;
  assign issue1 = m1_gnt & m1_req;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    case (state)
      OWN0: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wen   = m0_we & m0_req;
      end
      OWN1: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wen   = m1_we & m1_req;
      end
      default: ;
    endcase
  end

  assign tag_in.valid = (issue0 & ~m0_we) | (issue1 & ~m1_we);
  assign tag_in.own   = issue1;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= tag_out.valid & ~tag_out.own;
      m1_rvalid <= tag_out.valid & tag_out.own;
      if (tag_out.valid && !tag_out.own) m0_rdata <= mem_rdata;
      if (tag_out.valid && tag_out.own)  m1_rdata <= mem_rdata;
    end
  end

endmodule
